// File: rtl/bnn_pe_row_if.sv
// Bus bundle for one row of binary XNOR-popcount PEs (activations, psums, weights, status).
// valid_in qualifies activation_in/psum_in only on cycles with en_in=1; valid_out qualifies
// psum_out/overflow_out and holds while en_in=0. There is no ready: en_in=0 is the stall.
interface bnn_pe_row_if #(
  parameter int WIDTH      = 14,
  parameter int ROW_LENGTH = 11,
  parameter int VEC_W      = 27
);
  logic                        en_in;
  logic                        valid_in;
  logic [VEC_W*ROW_LENGTH-1:0] activation_in;
  logic [WIDTH-1:0]            psum_in;
  logic                        weight_load_in;
  logic [VEC_W*ROW_LENGTH-1:0] weight_in;
  logic [VEC_W*ROW_LENGTH-1:0] activation_out;
  logic [WIDTH-1:0]            psum_out;
  logic                        valid_out;
  logic                        overflow_out;
  logic                        busy_out;
  logic                        weight_err_out;

  modport master (
    output en_in, valid_in, activation_in, psum_in, weight_load_in, weight_in,
    input  activation_out, psum_out, valid_out, overflow_out, busy_out, weight_err_out
  );

  modport slave (
    input  en_in, valid_in, activation_in, psum_in, weight_load_in, weight_in,
    output activation_out, psum_out, valid_out, overflow_out, busy_out, weight_err_out
  );
endinterface

// File: rtl/bnn_pe_row_pipe.sv
// Pipelined row of XNOR-popcount PEs: psum chain, skewed activation segments, sticky overflow,
// global stall and a weight bank that only reloads while the row is empty.
module bnn_pe_row_pipe #(
  parameter int WIDTH      = 14,
  parameter int ROW_LENGTH = 11,
  parameter int VEC_W      = 27,
  parameter int LAST_W     = 18,
  parameter bit SATURATE   = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  bnn_pe_row_if.slave bus
);
  localparam int BUS_W  = VEC_W * ROW_LENGTH;
  localparam int CW     = $clog2(VEC_W + 1);
  localparam int SKEW_N = ROW_LENGTH * (ROW_LENGTH - 1) / 2;

  // Segment k owns a k-deep delay chain; chains are packed back to back in skew_q.
  function automatic int skew_base(input int k);
    return k * (k - 1) / 2;
  endfunction

  function automatic logic [VEC_W-1:0] seg(input logic [BUS_W-1:0] bus_v, input int k);
    return bus_v[VEC_W*(ROW_LENGTH-k)-1 -: VEC_W];
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [VEC_W-1:0] v, input int n);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if ((i < n) && v[i]) cnt = cnt + CW'(1);
    end
    return cnt;
  endfunction

  // Returns {carry, psum}; the carry marks the sample as overflowed in either mode.
  function automatic logic [WIDTH:0] pe_add(input logic [WIDTH-1:0] prev, input logic [CW-1:0] c);
    logic [WIDTH:0] sum;
    sum = {1'b0, prev} + (WIDTH+1)'(c);
    if (sum[WIDTH] && SATURATE) sum[WIDTH-1:0] = '1;
    return sum;
  endfunction

  logic [BUS_W-1:0]        weight_q;
  logic [BUS_W-1:0]        act_out_q;
  logic [VEC_W*SKEW_N-1:0] skew_q;
  logic [WIDTH-1:0]        psum_q [ROW_LENGTH];
  logic [ROW_LENGTH-1:0]   valid_q;
  logic [ROW_LENGTH-1:0]   ovf_q;
  logic                    weight_err_q;

  logic [WIDTH-1:0]        psum_d [ROW_LENGTH];
  logic [ROW_LENGTH-1:0]   valid_d;
  logic [ROW_LENGTH-1:0]   ovf_d;
  logic [WIDTH:0]          stage_sum;
  logic [VEC_W-1:0]        w0;
  logic                    busy;
  logic                    load_ok;

  assign busy    = |valid_q;
  assign load_ok = bus.weight_load_in & ~busy;

  always_comb begin
    valid_d   = '0;
    ovf_d     = '0;
    stage_sum = '0;
    w0        = '0;
    for (int k = 0; k < ROW_LENGTH; k++) psum_d[k] = '0;

    // A load accepted this cycle must already apply to a sample entering stage 0 now.
    w0         = load_ok ? seg(bus.weight_in, 0) : seg(weight_q, 0);
    stage_sum  = pe_add(bus.psum_in, popcount(~(seg(bus.activation_in, 0) ^ w0), VEC_W));
    psum_d[0]  = stage_sum[WIDTH-1:0];
    ovf_d[0]   = stage_sum[WIDTH];
    valid_d[0] = bus.valid_in;

    for (int k = 1; k < ROW_LENGTH; k++) begin
      stage_sum  = pe_add(psum_q[k-1],
                          popcount(~(skew_q[VEC_W*(skew_base(k)+k-1) +: VEC_W] ^ seg(weight_q, k)),
                                   (k == ROW_LENGTH-1) ? LAST_W : VEC_W));
      psum_d[k]  = stage_sum[WIDTH-1:0];
      ovf_d[k]   = ovf_q[k-1] | stage_sum[WIDTH];
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      act_out_q <= '0;
      skew_q    <= '0;
      valid_q   <= '0;
      ovf_q     <= '0;
      for (int k = 0; k < ROW_LENGTH; k++) psum_q[k] <= '0;
    end else if (bus.en_in) begin
      act_out_q <= bus.activation_in;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      for (int k = 0; k < ROW_LENGTH; k++) psum_q[k] <= psum_d[k];
      for (int k = 1; k < ROW_LENGTH; k++) begin
        for (int d = 0; d < k; d++) begin
          if (d == 0)
            skew_q[VEC_W*skew_base(k) +: VEC_W] <= seg(bus.activation_in, k);
          else
            skew_q[VEC_W*(skew_base(k)+d) +: VEC_W] <= skew_q[VEC_W*(skew_base(k)+d-1) +: VEC_W];
        end
      end
    end
  end

  // Weight bank ignores en_in; a load while samples are in flight is dropped and flagged.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      weight_q     <= '0;
      weight_err_q <= 1'b0;
    end else begin
      weight_err_q <= bus.weight_load_in & busy;
      if (load_ok) weight_q <= bus.weight_in;
    end
  end

  assign bus.activation_out = act_out_q;
  assign bus.psum_out       = psum_q[ROW_LENGTH-1];
  assign bus.valid_out      = valid_q[ROW_LENGTH-1];
  assign bus.overflow_out   = ovf_q[ROW_LENGTH-1];
  assign bus.busy_out       = busy;
  assign bus.weight_err_out = weight_err_q;
endmodule
